// File: rtl/coreriscv_axi4_locking_xbar_bus.sv
// ---------------------------------------------------------------------------
// coreriscv_axi4_locking_xbar_bus
//
// Purpose: NUM_IN sources compete through a locking round-robin arbiter.
// The winning beat is captured in a one-entry registered stage and steered
// to one of NUM_OUT destinations by its header dst. A multi-beat message
// (has_data=1, BEATS beats) keeps the grant until its last beat is accepted.
// Beats whose dst is out of range are accepted, discarded, and flagged on
// io_err_dst one cycle later.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   io_in_valid/ready per-source handshake (ready only on the granted source)
//   io_in_has_data    1 = BEATS-beat message, 0 = single beat
//   io_in_src/dst     packed headers, source i at [i*IDX_W +: IDX_W]
//   io_in_payload     packed payloads, source i at [i*PAYLOAD_W +: PAYLOAD_W]
//   io_out_valid      per-destination valid (stage valid & stage dst == k)
//   io_out_ready      per-destination ready
//   io_out_src/dst    registered header, shared by all destinations
//   io_out_payload    registered payload, shared by all destinations
//   io_chosen         currently granted source (combinational)
//   io_err_dst        one-cycle pulse for a dropped out-of-range beat
// ---------------------------------------------------------------------------
module coreriscv_axi4_locking_xbar_bus #(
  parameter int NUM_IN    = 4,
  parameter int NUM_OUT   = 4,
  parameter int IDX_W     = 3,
  parameter int PAYLOAD_W = 96,
  parameter int BEATS     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_IN-1:0]            io_in_valid,
  output logic [NUM_IN-1:0]            io_in_ready,
  input  logic [NUM_IN-1:0]            io_in_has_data,
  input  logic [NUM_IN*IDX_W-1:0]      io_in_src,
  input  logic [NUM_IN*IDX_W-1:0]      io_in_dst,
  input  logic [NUM_IN*PAYLOAD_W-1:0]  io_in_payload,
  output logic [NUM_OUT-1:0]           io_out_valid,
  input  logic [NUM_OUT-1:0]           io_out_ready,
  output logic [IDX_W-1:0]             io_out_src,
  output logic [IDX_W-1:0]             io_out_dst,
  output logic [PAYLOAD_W-1:0]         io_out_payload,
  output logic [IDX_W-1:0]             io_chosen,
  output logic                         io_err_dst
);

  localparam int SLOTS = 2 ** IDX_W;
  localparam int CNT_W = (BEATS > 2) ? $clog2(BEATS) : 1;

  // Stage-1 (registered output) state
  logic                 vld_p1_q, vld_p1_d;
  logic [IDX_W-1:0]     src_p1_q, src_p1_d;
  logic [IDX_W-1:0]     dst_p1_q, dst_p1_d;
  logic [PAYLOAD_W-1:0] payload_p1_q, payload_p1_d;
  logic                 err_q, err_d;

  // Arbiter / lock state
  logic                 lock_q, lock_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0]     lock_src_q, lock_src_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;

  // Inputs re-shaped into arrays covering every IDX_W index, so that any
  // header/grant value can index them directly; unused slots read as zero.
  logic                 in_valid_s    [SLOTS];
  logic                 in_has_data_s [SLOTS];
  logic [IDX_W-1:0]     in_src_s      [SLOTS];
  logic [IDX_W-1:0]     in_dst_s      [SLOTS];
  logic [PAYLOAD_W-1:0] in_payload_s  [SLOTS];
  logic                 out_ready_s   [SLOTS];

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    if (i < NUM_IN) begin : g_src
      assign in_valid_s[i]    = io_in_valid[i];
      assign in_has_data_s[i] = io_in_has_data[i];
      assign in_src_s[i]      = io_in_src[i*IDX_W +: IDX_W];
      assign in_dst_s[i]      = io_in_dst[i*IDX_W +: IDX_W];
      assign in_payload_s[i]  = io_in_payload[i*PAYLOAD_W +: PAYLOAD_W];
    end else begin : g_src_pad
      assign in_valid_s[i]    = 1'b0;
      assign in_has_data_s[i] = 1'b0;
      assign in_src_s[i]      = '0;
      assign in_dst_s[i]      = '0;
      assign in_payload_s[i]  = '0;
    end
    if (i < NUM_OUT) begin : g_dst
      assign out_ready_s[i] = io_out_ready[i];
    end else begin : g_dst_pad
      assign out_ready_s[i] = 1'b0;
    end
  end

  // ---- Stage 0: arbitration and input handshake ----
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] scan_idx;
  logic             any_vld;
  logic             grant_vld;

  always_comb begin
    any_vld  = 1'b0;
    grant    = last_grant_q;
    scan_idx = last_grant_q;
    // Scan upward from last_grant+1, wrapping at NUM_IN; first hit wins.
    for (int k = 0; k < NUM_IN; k++) begin
      if (scan_idx == IDX_W'(NUM_IN - 1)) scan_idx = '0;
      else                                scan_idx = scan_idx + 1'b1;
      if (!any_vld && in_valid_s[scan_idx]) begin
        any_vld = 1'b1;
        grant   = scan_idx;
      end
    end
    // A locked message owns the grant even while its source is idle.
    if (lock_q) begin
      grant     = lock_src_q;
      grant_vld = in_valid_s[lock_src_q];
    end else begin
      grant_vld = any_vld;
    end
  end

  logic out_fire;
  logic stage_free;
  logic accept;
  logic dst_ok;

  assign out_fire   = vld_p1_q & out_ready_s[dst_p1_q];
  assign stage_free = ~vld_p1_q | out_fire;
  assign accept     = grant_vld & stage_free & ~reset;
  assign dst_ok     = int'(in_dst_s[grant]) < NUM_OUT;

  assign io_chosen = grant;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_ready
    assign io_in_ready[i] = stage_free & ~reset & (grant == IDX_W'(i));
  end

  always_comb begin
    vld_p1_d     = vld_p1_q;
    src_p1_d     = src_p1_q;
    dst_p1_d     = dst_p1_q;
    payload_p1_d = payload_p1_q;
    err_d        = 1'b0;
    lock_d       = lock_q;
    beat_cnt_d   = beat_cnt_q;
    lock_src_d   = lock_src_q;
    last_grant_d = last_grant_q;

    // Load on a good accept; a simultaneous drain is simply overwritten.
    if (accept && dst_ok) begin
      vld_p1_d     = 1'b1;
      src_p1_d     = in_src_s[grant];
      dst_p1_d     = in_dst_s[grant];
      payload_p1_d = in_payload_s[grant];
    end else if (out_fire) begin
      vld_p1_d = 1'b0;
    end

    // Bad-dst beats still count toward the lock so the message drains whole.
    if (accept) begin
      err_d = ~dst_ok;
      if (!lock_q) begin
        if (in_has_data_s[grant]) begin
          lock_d     = 1'b1;
          beat_cnt_d = CNT_W'(1);
          lock_src_d = grant;
        end else begin
          last_grant_d = grant;
        end
      end else if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
        lock_d       = 1'b0;
        beat_cnt_d   = '0;
        last_grant_d = lock_src_q;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q     <= 1'b0;
      err_q        <= 1'b0;
      lock_q       <= 1'b0;
      beat_cnt_q   <= '0;
      lock_src_q   <= '0;
      last_grant_q <= IDX_W'(NUM_IN - 1);
    end else begin
      vld_p1_q     <= vld_p1_d;
      err_q        <= err_d;
      lock_q       <= lock_d;
      beat_cnt_q   <= beat_cnt_d;
      lock_src_q   <= lock_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_ff @(posedge clk) begin
    src_p1_q     <= src_p1_d;
    dst_p1_q     <= dst_p1_d;
    payload_p1_q <= payload_p1_d;
  end

  // ---- Stage 1: registered outputs ----
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_route
    assign io_out_valid[k] = vld_p1_q & ~reset & (dst_p1_q == IDX_W'(k));
  end

  assign io_out_src     = src_p1_q;
  assign io_out_dst     = dst_p1_q;
  assign io_out_payload = payload_p1_q;
  assign io_err_dst     = err_q & ~reset;

endmodule
